tcp_slow_path_send_q: RTL
=========================

# tcp_slow_path_send_q

Buffers SYN-ACK send requests produced by the TCP RX slow path (header, flow ID, source/destination IP) and hands them one at a time to the TX header/packet merger. It decouples the RX slow-path controller, which emits one request per new flow, from TX, which may stall. The block is a DEPTH-entry FIFO with valid/ready on both sides, occupancy status and a saturating stall counter for debug.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- LOG_DEPTH, $clog2(DEPTH), pointer index width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- slow_path_send_pkt_enqueue_val  in  1  request valid
- slow_path_send_pkt_enqueue_rdy  out  1  queue can accept
- slow_path_send_pkt_enqueue_pkt  in  tcp_pkt_hdr  header to send
- slow_path_send_pkt_enqueue_flowid  in  FLOWID_W  flow ID
- slow_path_send_pkt_enqueue_src_ip  in  `IP_ADDR_W  our IP
- slow_path_send_pkt_enqueue_dst_ip  in  `IP_ADDR_W  peer IP
- slow_path_send_pkt_dequeue_val  out  1  head entry valid
- slow_path_send_pkt_dequeue_rdy  in  1  TX consumes head
- slow_path_send_pkt_dequeue_pkt  out  tcp_pkt_hdr  head header
- slow_path_send_pkt_dequeue_flowid  out  FLOWID_W  head flow ID
- slow_path_send_pkt_dequeue_src_ip  out  `IP_ADDR_W  head source IP
- slow_path_send_pkt_dequeue_dst_ip  out  `IP_ADDR_W  head destination IP
- send_q_occupancy  out  LOG_DEPTH+1  entries held, 0..DEPTH
- send_q_stall_cnt  out  16  cycles with enqueue_val=1 and enqueue_rdy=0; saturates at 16'hFFFF

## Operation
- State: storage array of DEPTH slow_path_send_q_struct, wr_ptr and rd_ptr of LOG_DEPTH+1 bits. The MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr). full = index bits equal and wrap bits differ.
- occupancy = wr_ptr − rd_ptr, computed modulo 2^(LOG_DEPTH+1).
- enqueue_rdy = !full & !rst. An enqueue fires on val & rdy: the entry is written at wr_ptr[LOG_DEPTH-1:0] and wr_ptr increments.
- dequeue_val = !empty. Dequeue data is the entry at rd_ptr, gated to '0 when empty. A dequeue fires on val & rdy and rd_ptr increments.
- Simultaneous enqueue and dequeue with 0 < occupancy < DEPTH: both fire and occupancy is unchanged.
- When full, enqueue_rdy=0 even if a dequeue fires that same cycle. There is no same-cycle pass-through when full.
- When empty, an enqueue does not make dequeue_val high in the same cycle. There is no bypass.
- Pointers wrap naturally. Order is strict FIFO. Entries are never dropped or reordered.
- The stall counter increments by 1 each cycle where enqueue_val & !enqueue_rdy, and holds at 16'hFFFF.
- Reset, including mid-operation: both pointers and the stall counter go to 0, and all queued entries are discarded.
  - Reset values: dequeue_val=0, all dequeue data '0, occupancy=0, stall_cnt=0.
  - enqueue_rdy=0 while rst is high and 1 in the first cycle after.
  - Storage contents are not reset.

## Timing
- Enqueue to dequeue latency is 1 cycle: an enqueue accepted at edge N into an empty queue gives dequeue_val=1 with that entry's data after edge N.
- Throughput is one enqueue and one dequeue per cycle.
- enqueue_rdy depends only on registered state, with no combinational path from dequeue_rdy.
- dequeue_val and dequeue data are combinational from registers only.
- occupancy and stall_cnt reflect state after the last edge.

## Structure
- tcp_misc_pkg gains slow_path_send_q_struct = {tcp_pkt_hdr pkt; FLOWID_W flowid; `IP_ADDR_W src_ip; `IP_ADDR_W dst_ip}.
- The storage array is the one sub-module, slow_path_send_q_mem (1 write port, 1 asynchronous read port, parameterised on DEPTH and width).
- Pointers, flags and counter live in the top module.

## Test plan
- Reset, then enqueue one request (flowid=3, src_ip=0x0A000001, dst_ip=0x0A000002, seq_num=0xFF, ack_num=0x1235) -> dequeue_val=1 one cycle later with identical fields, occupancy=1; dequeue_rdy=1 -> occupancy=0 and dequeue_val=0 next cycle.
- Fill: 8 enqueues (flowid 0..7) with dequeue_rdy=0 -> occupancy=8, enqueue_rdy=0; hold enqueue_val=1 for 5 more cycles -> stall_cnt=5; then drain -> flowids 0..7 in order.
- Full plus simultaneous: at occupancy=8, enqueue_val=1 and dequeue_rdy=1 -> only the dequeue fires, occupancy=7, enqueue_rdy=1 next cycle.
- Streaming wrap: enqueue 20 entries continuously while dequeue_rdy=1 -> occupancy never exceeds 1 and flowids come out 0..19 in order across pointer wrap.
- Reset mid-operation: occupancy=5 and rst pulsed for 1 cycle -> occupancy=0, dequeue_val=0, data '0, stall_cnt=0; the next enqueue is the first entry dequeued.
- Stall saturation: hold enqueue_val=1 while full for 70000 cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/tcp_misc_pkg.sv
// ---------------------------------------------------------------------------
// tcp_misc_pkg
//   Shared types for the TCP slow-path send queue.
//   - tcp_pkt_hdr             : header fields the RX slow path hands to TX
//   - slow_path_send_q_struct : one queued send request
//                               (header + flow ID + source/destination IP)
//   - sat_inc16               : saturating 16-bit increment used by the
//                               debug stall counter
// ---------------------------------------------------------------------------
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package tcp_misc_pkg;

   localparam int FLOWID_W    = 8;
   localparam int IP_ADDR_W   = `IP_ADDR_W;
   localparam int STALL_CNT_W = 16;

   localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

   typedef struct packed {
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [31:0] seq_num;
      logic [31:0] ack_num;
      logic [7:0]  flags;
      logic [15:0] window;
   } tcp_pkt_hdr;

   typedef struct packed {
      tcp_pkt_hdr              pkt;
      logic [FLOWID_W-1:0]     flowid;
      logic [`IP_ADDR_W-1:0]   src_ip;
      logic [`IP_ADDR_W-1:0]   dst_ip;
   } slow_path_send_q_struct;

   localparam int SEND_Q_ENTRY_W = $bits(slow_path_send_q_struct);

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic logic [STALL_CNT_W-1:0] sat_inc16(input logic [STALL_CNT_W-1:0] value);
      if (value == STALL_CNT_MAX) begin
         return value;
      end
      return value + STALL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/slow_path_send_q_mem.sv
// ---------------------------------------------------------------------------
// slow_path_send_q_mem
//   Storage array for the slow-path send queue: DEPTH words of WIDTH bits,
//   one synchronous write port and one asynchronous (combinational) read port.
//
//   Ports
//     clk      in   clock
//     wr_en    in   write strobe
//     wr_addr  in   write index
//     wr_data  in   write word
//     rd_addr  in   read index
//     rd_data  out  word at rd_addr, combinational
// ---------------------------------------------------------------------------
module slow_path_send_q_mem #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int LOG_DEPTH = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [LOG_DEPTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic [LOG_DEPTH-1:0] rd_addr,
   output logic [WIDTH-1:0]     rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; a word is only ever read after it has
   // been written, because the pointers (which are reset) gate validity.
   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tcp_slow_path_send_q.sv
// ---------------------------------------------------------------------------
// tcp_slow_path_send_q
//   DEPTH-entry FIFO that buffers SYN-ACK send requests from the TCP RX slow
//   path and hands them, one per cycle at most, to the TX merger.
//
//   Ports
//     clk, rst                              clock, synchronous active-high reset
//     slow_path_send_pkt_enqueue_*          producer side: val/rdy + request
//     slow_path_send_pkt_dequeue_*          consumer side: val/rdy + head entry
//     send_q_occupancy                      entries held, 0..DEPTH
//     send_q_stall_cnt                      saturating count of cycles the
//                                           producer was held off
//
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate counter. Dequeue data is read straight from the
//   storage array (no output register), so a request written at edge N is
//   visible right after edge N. There is no bypass when empty and no
//   pass-through when full: enqueue_rdy depends only on registered state
//   and rst.
// ---------------------------------------------------------------------------
module tcp_slow_path_send_q
   import tcp_misc_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int LOG_DEPTH = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   slow_path_send_pkt_enqueue_val,
   output logic                   slow_path_send_pkt_enqueue_rdy,
   input  tcp_pkt_hdr             slow_path_send_pkt_enqueue_pkt,
   input  logic [FLOWID_W-1:0]    slow_path_send_pkt_enqueue_flowid,
   input  logic [IP_ADDR_W-1:0]   slow_path_send_pkt_enqueue_src_ip,
   input  logic [IP_ADDR_W-1:0]   slow_path_send_pkt_enqueue_dst_ip,

   output logic                   slow_path_send_pkt_dequeue_val,
   input  logic                   slow_path_send_pkt_dequeue_rdy,
   output tcp_pkt_hdr             slow_path_send_pkt_dequeue_pkt,
   output logic [FLOWID_W-1:0]    slow_path_send_pkt_dequeue_flowid,
   output logic [IP_ADDR_W-1:0]   slow_path_send_pkt_dequeue_src_ip,
   output logic [IP_ADDR_W-1:0]   slow_path_send_pkt_dequeue_dst_ip,

   output logic [LOG_DEPTH:0]     send_q_occupancy,
   output logic [STALL_CNT_W-1:0] send_q_stall_cnt
);

   localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH+1)'(1);

   logic [LOG_DEPTH:0]     wr_ptr;
   logic [LOG_DEPTH:0]     rd_ptr;
   logic [STALL_CNT_W-1:0] stall_cnt;

   logic empty;
   logic full;
   logic enq_fire;
   logic deq_fire;
   logic stall_evt;

   slow_path_send_q_struct    wr_entry;
   slow_path_send_q_struct    rd_entry;
   slow_path_send_q_struct    head_entry;
   logic [SEND_Q_ENTRY_W-1:0] rd_bits;

   // ---------------------------------------------------------------- flags
   assign empty = (wr_ptr == rd_ptr);
   // Same slot index but opposite lap: the writer is a full lap ahead.
   assign full  = (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]) &&
                  (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]);

   assign slow_path_send_pkt_enqueue_rdy = !full && !rst;
   assign slow_path_send_pkt_dequeue_val = !empty;

   assign enq_fire  = slow_path_send_pkt_enqueue_val && slow_path_send_pkt_enqueue_rdy;
   assign deq_fire  = slow_path_send_pkt_dequeue_val && slow_path_send_pkt_dequeue_rdy;
   assign stall_evt = slow_path_send_pkt_enqueue_val && !slow_path_send_pkt_enqueue_rdy;

   // Modulo 2^(LOG_DEPTH+1) difference; the wrap bit makes DEPTH representable.
   assign send_q_occupancy = wr_ptr - rd_ptr;
   assign send_q_stall_cnt = stall_cnt;

   // ------------------------------------------------------------- pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq_fire) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (deq_fire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // ---------------------------------------------------------- stall count
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_evt) begin
         stall_cnt <= sat_inc16(stall_cnt);
      end
   end

   // -------------------------------------------------------------- storage
   always_comb begin
      wr_entry.pkt    = slow_path_send_pkt_enqueue_pkt;
      wr_entry.flowid = slow_path_send_pkt_enqueue_flowid;
      wr_entry.src_ip = slow_path_send_pkt_enqueue_src_ip;
      wr_entry.dst_ip = slow_path_send_pkt_enqueue_dst_ip;
   end

   slow_path_send_q_mem #(
      .DEPTH     (DEPTH),
      .WIDTH     (SEND_Q_ENTRY_W),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (enq_fire),
      .wr_addr (wr_ptr[LOG_DEPTH-1:0]),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr[LOG_DEPTH-1:0]),
      .rd_data (rd_bits)
   );

   assign rd_entry = slow_path_send_q_struct'(rd_bits);

   // Stale or never-written slots must not leak onto the output bus.
   // NOTE: an always_comb that assigns its outputs a default before any
   // condition cannot infer a latch.
   always_comb begin
      head_entry = '0;
      if (!empty) begin
         head_entry = rd_entry;
      end
   end

   assign slow_path_send_pkt_dequeue_pkt    = head_entry.pkt;
   assign slow_path_send_pkt_dequeue_flowid = head_entry.flowid;
   assign slow_path_send_pkt_dequeue_src_ip = head_entry.src_ip;
   assign slow_path_send_pkt_dequeue_dst_ip = head_entry.dst_ip;

endmodule
